// File: rtl/veda_lsu.sv
// veda_lsu: single-outstanding load/store unit for a 512-word data memory.
// Ports: clk/rst_n (sync, active-low); req_* request channel (valid/ready,
// store flag, base + signed word offset, store data, load tag); mem_* data
// memory strobe, mode (0 write, 1 read), address, write data, read data;
// rsp_* response channel (valid/ready, load flag, tag, data, error).
// Define VEDA_LSU_BOUNDS_CHECK_EN to reject addresses beyond 9 bits.
module veda_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_base,
  input  logic [15:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_w_en,
  output logic        mem_mode,
  output logic [8:0]  mem_address,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_load,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
`ifdef VEDA_LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] w_ea;
  logic        w_hs, w_oob;
  logic        r_mem_w_en, r_mem_mode, r_rsp_valid, r_rsp_load, r_rsp_err;
  logic [8:0]  r_mem_address;
  logic [31:0] r_mem_datain, r_rsp_data;
  logic [4:0]  r_rsp_rd;
  assign w_ea  = req_base + {{16{req_offset[15]}}, req_offset};
  assign w_hs  = req_valid && (r_state == IDLE);
  assign w_oob = BOUNDS_CHECK && (|w_ea[31:9]);
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid ? (w_oob ? RESP : ACCESS) : IDLE;
      ACCESS:  w_next = r_rsp_load ? WAIT : RESP;
      WAIT:    w_next = RESP;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // Memory outputs are loaded at the handshake so the strobe is high for
  // exactly the ACCESS cycle; rejected requests leave them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_w_en    <= 1'b0;
      r_mem_mode    <= 1'b0;
      r_mem_address <= '0;
      r_mem_datain  <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_load    <= 1'b0;
      r_rsp_rd      <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_mem_w_en  <= w_hs && !w_oob;
      r_rsp_valid <= (w_next == RESP);
      if (w_hs) begin
        r_rsp_load <= !req_store;
        r_rsp_rd   <= req_rd;
        r_rsp_err  <= w_oob;
        r_rsp_data <= '0;
        if (!w_oob) begin
          r_mem_mode    <= !req_store;
          r_mem_address <= w_ea[8:0];
          r_mem_datain  <= req_store ? req_wdata : '0;
        end
      end
      if (r_state == WAIT) r_rsp_data <= mem_dataout;
    end
  end
  assign req_ready   = (r_state == IDLE);
  assign mem_w_en    = r_mem_w_en;
  assign mem_mode    = r_mem_mode;
  assign mem_address = r_mem_address;
  assign mem_datain  = r_mem_datain;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_load    = r_rsp_load;
  assign rsp_rd      = r_rsp_rd;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
endmodule

// File: tb/tb_veda_lsu.sv
// tb_veda_lsu: scoreboard bench for veda_lsu with a behavioural data memory.
module tb_veda_lsu;
`ifdef VEDA_LSU_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic        clk = 0;
  logic        rst_n, req_valid, req_ready, req_store;
  logic [31:0] req_base, req_wdata;
  logic [15:0] req_offset;
  logic [4:0]  req_rd;
  logic        mem_w_en, mem_mode;
  logic [8:0]  mem_address;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout = 0;
  logic        rsp_valid, rsp_ready, rsp_load, rsp_err;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  veda_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_w_en(mem_w_en),
    .mem_mode(mem_mode), .mem_address(mem_address), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_load(rsp_load), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic ld; logic [4:0] rd; logic [31:0] data; logic err;} exp_t;
  exp_t        sb[$];
  exp_t        e_mon, e_drop;
  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  int          checks = 0, errors = 0;
  int          cyc = 0, strobe_cnt = 0, hs_cnt = 0, last_hs = 0;
  logic        last_mode = 0;
  logic [8:0]  last_addr = 0;
  logic [31:0] last_data = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_w_en) begin
    if (mem_mode) mem_dataout <= mem[mem_address];
    else          mem[mem_address] <= mem_datain;
    strobe_cnt <= strobe_cnt + 1;
    last_mode  <= mem_mode;
    last_addr  <= mem_address;
    last_data  <= mem_datain;
  end
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) hs_cnt++;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e_mon = sb.pop_front();
        chk("rsp_load", rsp_load, e_mon.ld);
        chk("rsp_rd", rsp_rd, e_mon.rd);
        chk("rsp_data", rsp_data, e_mon.data);
        chk("rsp_err", rsp_err, e_mon.err);
      end
    end
  end
  task automatic drive(input logic st, input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1; req_store = st; req_base = base; req_offset = off;
    req_wdata = wd; req_rd = rd;
  endtask
  task automatic wait_hs();
    logic r;
    bit ok;
    logic [31:0] ea;
    exp_t x;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1;
      ok = r;
    end
    if (!ok) begin
      chk("hs_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    last_hs = cyc;
    ea = req_base + {{16{req_offset[15]}}, req_offset};
    x.err = BC && (ea[31:9] != 0);
    x.ld = !req_store;
    x.rd = req_rd;
    x.data = (req_store || x.err) ? 32'h0 : ref_mem[ea[8:0]];
    if (req_store && !x.err) ref_mem[ea[8:0]] = req_wdata;
    sb.push_back(x);
    req_valid = 0;
  endtask
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic xact(input string t, input logic st, input logic [31:0] base,
                      input logic [15:0] off, input logic [31:0] wd, input logic [4:0] rd,
                      input int lat, input int ns, input logic [8:0] addr);
    int n, s0;
    s0 = strobe_cnt;
    drive(st, base, off, wd, rd);
    wait_hs();
    wait_rsp(n);
    chk({t, "_lat"}, n, lat);
    chk({t, "_strobes"}, strobe_cnt - s0, ns);
    if (ns == 1) begin
      chk({t, "_mode"}, last_mode, !st);
      chk({t, "_addr"}, last_addr, addr);
      chk({t, "_wdata"}, last_data, st ? wd : 32'h0);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int n, c0, h0, prev, prev_st;
    logic st;
    for (int i = 0; i < 512; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    rst_n = 0; rsp_ready = 1;
    req_valid = 0; req_store = 0; req_base = 0; req_offset = 0; req_wdata = 0; req_rd = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_w_en", mem_w_en, 0);
    chk("rst_mem_mode", mem_mode, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_datain", mem_datain, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_load", rsp_load, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1;
    @(posedge clk); #1;
    xact("st5", 1, 5, 0, 9, 0, 2, 1, 5);
    xact("ld5", 0, 5, 0, 0, 3, 3, 1, 5);
    xact("neg", 0, 10, 16'hFFF7, 0, 4, 3, 1, 1);
    xact("wrap_st", 1, 32'hFFFF_FFFF, 2, 32'hABCD_1234, 6, 2, 1, 1);
    xact("wrap_ld", 0, 32'h0000_0100, 16'hFF01, 0, 8, 3, 1, 1);
    xact("st0", 1, 0, 0, 32'h77, 0, 2, 1, 0);
    xact("oob", 0, 32'h200, 0, 0, 9, BC ? 1 : 3, BC ? 0 : 1, 0);
    rsp_ready = 0;
    h0 = hs_cnt;
    drive(0, 5, 0, 0, 7);
    wait_hs();
    drive(1, 20, 0, 32'h55, 2);
    wait_rsp(n);
    chk("bp_lat", n, 3);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 9);
      chk("bp_rd", rsp_rd, 7);
      chk("bp_load", rsp_load, 1);
      chk("bp_req_ready", req_ready, 0);
    end
    c0 = cyc;
    rsp_ready = 1;
    wait_hs();
    chk("bp_gap", last_hs - c0, 2);
    wait_rsp(n);
    chk("bp_st_lat", n, 2);
    @(posedge clk); #1;
    chk("bp_hs_count", hs_cnt - h0, 2);
    drive(0, 5, 0, 0, 4);
    wait_hs();
    @(posedge clk); #1;
    rst_n = 0;
    e_drop = sb.pop_back();
    @(posedge clk); #1;
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_mem_w_en", mem_w_en, 0);
    chk("rw_req_ready", req_ready, 1);
    chk("rw_mem_address", mem_address, 0);
    chk("rw_mem_mode", mem_mode, 0);
    chk("rw_mem_datain", mem_datain, 0);
    chk("rw_rsp_rd", rsp_rd, 0);
    chk("rw_rsp_data", rsp_data, 0);
    chk("rw_rsp_load", rsp_load, 0);
    chk("rw_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rw_no_rsp", rsp_valid, 0);
    end
    xact("rw_ld", 0, 5, 0, 0, 11, 3, 1, 5);
    prev = 0; prev_st = 0;
    for (int i = 0; i < 6; i++) begin
      st = (i % 2 == 0);
      drive(st, 32 + i / 2, 0, i * 3 + 1, 5'(i));
      wait_hs();
      if (i > 0) chk("tput_gap", last_hs - prev, prev_st ? 3 : 4);
      prev = last_hs;
      prev_st = st;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
